rec_play_ctrl: RTL and testbench

//  Record/playback sequencer for the piezo keyboard. It owns a two-slot note memory and time-shares the single tone output.
//  The tone output is driven by live keys, by the recorder monitor or by the playback engine.

---
 rtl/rec_play_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_rec_play_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer: two note slots, live passthrough, and one shared tone output.
// Define LOOP_PLAY_EN to make playback repeat until rw rises or the starting slot button rises again.
module rec_play_ctrl #(
    parameter int SLOT_DEPTH = 32,
    parameter int TICK_DIV   = 6250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_in,
    input  logic       rw,
    input  logic       slot_one,
    input  logic       slot_two,
    output logic [7:0] tone_key,
    output logic       tone_en,
    output logic       rec_busy,
    output logic       play_busy,
    output logic       done,
    output logic       overflow
);
    localparam int PW = $clog2(SLOT_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE = 2'd0, REC = 2'd1, PLAY = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          slot_q, slot_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rd_end_q, rd_end_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len0_q, len0_d, len1_q, len1_d;
    logic          s1_q, s1_d, s2_q, s2_d;
    logic [7:0]    tone_key_q, tone_key_d;
    logic          done_q, done_d;
    logic          overflow_q, overflow_d;

    logic [7:0]    mem [2*SLOT_DEPTH];
    logic          mem_we;
    logic [LW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    logic          req_one, req_two, tick, stop_req;
    logic [LW-1:0] len_sel;

    assign req_one = slot_one & ~s1_q;
    assign req_two = slot_two & ~s2_q;
    assign tick    = (cnt_q == CW'(TICK_DIV - 1));
    assign len_sel = slot_q ? len1_q : len0_q;

`ifdef LOOP_PLAY_EN
    assign stop_req = slot_q ? req_two : req_one;
`else
    assign stop_req = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_end_d   = rd_end_q;
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        len0_d     = len0_q;
        len1_d     = len1_q;
        s1_d       = slot_one;
        s2_d       = slot_two;
        tone_key_d = tone_key_q;
        done_d     = 1'b0;
        overflow_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = {slot_q, wr_ptr_q};
        mem_wdata  = key_in;

        case (state_q)
            IDLE: begin
                tone_key_d = key_in;
                cnt_d      = '0;
                if (req_one || req_two) begin
                    slot_d   = ~req_one;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    rd_end_d = 1'b0;
                    if (rw) begin
                        state_d = REC;
                    end else begin
                        state_d    = PLAY;
                        tone_key_d = '0;
                    end
                end
            end
            REC: begin
                tone_key_d = key_in;
                if (!rw) begin
                    if (slot_q) len1_d = {1'b0, wr_ptr_q};
                    else        len0_d = {1'b0, wr_ptr_q};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tick) begin
                    mem_we = 1'b1;
                    if (wr_ptr_q == PW'(SLOT_DEPTH - 1)) begin
                        if (slot_q) len1_d = LW'(SLOT_DEPTH);
                        else        len0_d = LW'(SLOT_DEPTH);
                        overflow_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    end
                end
            end
            PLAY: begin
                // While in PLAY rw can only be high after rising, since entry requires rw low.
                if (rw || len_sel == '0 || stop_req) begin
                    tone_key_d = '0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else if (tick) begin
                    if (!rd_end_q) begin
                        tone_key_d = mem[{slot_q, rd_ptr_q}];
                        if (({1'b0, rd_ptr_q} + LW'(1)) == len_sel) rd_end_d = 1'b1;
                        else                                       rd_ptr_d = rd_ptr_q + PW'(1);
                    end else begin
`ifdef LOOP_PLAY_EN
                        tone_key_d = mem[{slot_q, {PW{1'b0}}}];
                        if (len_sel != LW'(1)) begin
                            rd_ptr_d = PW'(1);
                            rd_end_d = 1'b0;
                        end
`else
                        tone_key_d = '0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            slot_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_end_q   <= 1'b0;
            cnt_q      <= '0;
            len0_q     <= '0;
            len1_q     <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            tone_key_q <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_end_q   <= rd_end_d;
            cnt_q      <= cnt_d;
            len0_q     <= len0_d;
            len1_q     <= len1_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            tone_key_q <= tone_key_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    // Note memory carries no reset; len gates every read.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign tone_key  = tone_key_q;
    assign tone_en   = |tone_key_q;
    assign rec_busy  = (state_q == REC);
    assign play_busy = (state_q == PLAY);
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Bench for rec_play_ctrl: directed scenarios with literal pins, then random stimulus,
// all checked every cycle against a note-list model of the recorder.
module tb_rec_play_ctrl;
    localparam int TD = 4;
    localparam int SD = 4;
`ifdef LOOP_PLAY_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_in = '0;
    logic       rw = 1'b0;
    logic       slot_one = 1'b0;
    logic       slot_two = 1'b0;
    logic [7:0] tone_key;
    logic       tone_en, rec_busy, play_busy, done, overflow;

    rec_play_ctrl #(.SLOT_DEPTH(SD), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .rw(rw),
        .slot_one(slot_one), .slot_two(slot_two),
        .tone_key(tone_key), .tone_en(tone_en), .rec_busy(rec_busy),
        .play_busy(play_busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: recordings as note lists, time as cycles spent in the current mode.
    int         m_mode = 0;   // 0 idle, 1 recording, 2 playing
    bit         m_slot = 1'b0;
    int         m_age = 0;
    int         m_ticks = 0;
    bit         p1 = 1'b0, p2 = 1'b0;
    logic [7:0] notes0[$], notes1[$], rec_buf[$];
    logic [7:0] e_tone = '0;
    bit         e_done = 1'b0, e_ovf = 1'b0;
    logic [12:0] exp_q[$];

    bit         logging = 1'b0;
    logic [7:0] obs_tone[$];
    bit         obs_done[$], obs_ovf[$];

    function automatic int nlen(bit s);
        return s ? notes1.size() : notes0.size();
    endfunction

    function automatic logic [7:0] nget(bit s, int i);
        return s ? notes1[i] : notes0[i];
    endfunction

    task automatic store(bit s);
        if (s) notes1 = rec_buf;
        else   notes0 = rec_buf;
    endtask

    task automatic model_step();
        bit r1, r2, tk, stop;
        int len;
        logic [7:0] nt;
        if (rst) begin
            m_mode = 0; e_tone = '0; e_done = 0; e_ovf = 0;
            notes0.delete(); notes1.delete();
            p1 = 0; p2 = 0;
        end else begin
            r1 = slot_one && !p1;
            r2 = slot_two && !p2;
            p1 = slot_one;
            p2 = slot_two;
            tk = (m_age % TD) == TD - 1;
            e_done = 0; e_ovf = 0;
            nt = e_tone;
            case (m_mode)
                0: begin
                    nt = key_in;
                    if (r1 || r2) begin
                        m_slot = !r1; m_age = 0; m_ticks = 0; rec_buf.delete();
                        if (rw) m_mode = 1;
                        else begin m_mode = 2; nt = '0; end
                    end
                end
                1: begin
                    nt = key_in;
                    if (!rw) begin
                        store(m_slot); e_done = 1; m_mode = 0;
                    end else if (tk) begin
                        rec_buf.push_back(key_in);
                        if (rec_buf.size() == SD) begin
                            store(m_slot); e_done = 1; e_ovf = 1; m_mode = 0;
                        end
                    end
                    m_age++;
                end
                default: begin
                    len = nlen(m_slot);
                    stop = LOOP && (m_slot ? r2 : r1);
                    if (rw || len == 0 || stop) begin
                        nt = '0; e_done = 1; m_mode = 0;
                    end else if (tk) begin
                        m_ticks++;
                        if (!LOOP && m_ticks > len) begin
                            nt = '0; e_done = 1; m_mode = 0;
                        end else begin
                            nt = nget(m_slot, (m_ticks - 1) % len);
                        end
                    end
                    m_age++;
                end
            endcase
            e_tone = nt;
        end
        exp_q.push_back({m_mode == 2, m_mode == 1, e_ovf, e_done, |e_tone, e_tone});
    endtask

    task automatic check();
        logic [12:0] exp_v, got_v;
        exp_v = exp_q.pop_front();
        got_v = {play_busy, rec_busy, overflow, done, tone_en, tone_key};
        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL cycle %0d outputs {play,rec,ovf,done,en,tone}: got %b_%b_%b_%b_%b_%h required %b_%b_%b_%b_%b_%h",
                     cyc, got_v[12], got_v[11], got_v[10], got_v[9], got_v[8], got_v[7:0],
                     exp_v[12], exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
        end
        if (logging) begin
            obs_tone.push_back(tone_key);
            obs_done.push_back(done);
            obs_ovf.push_back(overflow);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check();
    endtask

    task automatic pin(input string name, input int got, input int req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic log_start();
        obs_tone.delete(); obs_done.delete(); obs_ovf.delete();
        logging = 1'b1;
    endtask

    logic [7:0] exp_play [17] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01,
                                  8'h04, 8'h04, 8'h04, 8'h04, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00};

    initial begin
        int err;
        cycle(); cycle();
        pin("reset_outputs", {tone_key, tone_en, rec_busy, play_busy, done, overflow}, 0);
        rst = 1'b0;

        // Reset in the middle of a recording empties the slot.
        rw = 1'b1; slot_one = 1'b1; cycle(); slot_one = 1'b0;
        key_in = 8'h3c; repeat (6) cycle();
        pin("rec_busy_before_rst", rec_busy, 1);
        rst = 1'b1; cycle(); rst = 1'b0;
        pin("rst_mid_rec_outputs", {tone_key, rec_busy, play_busy, done, overflow}, 0);
        rw = 1'b0; key_in = '0; cycle();
        slot_one = 1'b1; log_start(); cycle(); slot_one = 1'b0; repeat (3) cycle(); logging = 1'b0;
        err = 0;
        foreach (obs_tone[i]) if (obs_tone[i] != 0) err++;
        pin("empty_play_tone_nonzero_count", err, 0);
        pin("empty_play_done", obs_done[1], 1);

        // Three notes into slot 0, then a single-pass playback.
        rw = 1'b1; slot_one = 1'b1; key_in = 8'h01; cycle(); slot_one = 1'b0;
        repeat (4) cycle();
        key_in = 8'h04; repeat (4) cycle();
        key_in = 8'h10; repeat (4) cycle();
        rw = 1'b0; key_in = '0; cycle();
        pin("rec3_done", done, 1);
        cycle();
        slot_one = 1'b1; log_start(); cycle(); slot_one = 1'b0; repeat (17) cycle(); logging = 1'b0;
        err = 0;
        for (int i = 0; i < 16; i++) if (obs_tone[i] != exp_play[i]) err++;
        if (!LOOP && obs_tone[16] != exp_play[16]) err++;
        pin("play3_seq_errors", err, 0);
        if (!LOOP) pin("play3_done", obs_done[16], 1);

        // Overflowing slot 1 keeps the first four notes.
        rw = 1'b1; slot_two = 1'b1; key_in = 8'h11; log_start(); cycle(); slot_two = 1'b0;
        repeat (4) cycle();
        key_in = 8'h22; repeat (4) cycle();
        key_in = 8'h33; repeat (4) cycle();
        key_in = 8'h44; repeat (4) cycle();
        key_in = 8'h55; repeat (4) cycle();
        logging = 1'b0;
        err = 0;
        foreach (obs_ovf[i]) if (obs_ovf[i]) err++;
        pin("overflow_pulses", err, 1);
        pin("overflow_index", obs_ovf[16], 1);
        pin("rec_busy_after_overflow", rec_busy, 0);
        rw = 1'b0; key_in = '0; cycle();
        slot_two = 1'b1; log_start(); cycle(); slot_two = 1'b0; repeat (20) cycle(); logging = 1'b0;
        err = 0;
        if (obs_tone[4] != 8'h11) err++;
        if (obs_tone[8] != 8'h22) err++;
        if (obs_tone[12] != 8'h33) err++;
        if (obs_tone[16] != 8'h44) err++;
        if (!LOOP && (obs_tone[20] != 8'h00 || !obs_done[20])) err++;
        pin("play4_seq_errors", err, 0);

        // Simultaneous edges select slot 0; slot 1 edges during play do nothing.
        slot_one = 1'b1; slot_two = 1'b1; log_start(); cycle();
        slot_one = 1'b0; slot_two = 1'b0; cycle();
        slot_two = 1'b1; cycle(); slot_two = 1'b0; cycle();
        slot_two = 1'b1; repeat (3) cycle(); slot_two = 1'b0; repeat (12) cycle();
        logging = 1'b0;
        err = 0;
        for (int i = 0; i < 16; i++) if (obs_tone[i] != exp_play[i]) err++;
        pin("both_edges_seq_errors", err, 0);
        rw = 1'b1; cycle(); rw = 1'b0; cycle();

        // Live passthrough, then abort by rw.
        key_in = 8'h80; cycle();
        pin("live_tone_key", tone_key, 8'h80);
        pin("live_tone_en", tone_en, 1);
        key_in = '0; cycle();
        slot_one = 1'b1; cycle(); slot_one = 1'b0; repeat (6) cycle();
        pin("abort_pre_tone", tone_key, 8'h01);
        rw = 1'b1; cycle();
        pin("abort_tone", tone_key, 0);
        pin("abort_done", done, 1);
        rw = 1'b0; cycle();

        // Two-note slot 0: single pass or looping depending on build.
        rw = 1'b1; slot_one = 1'b1; key_in = 8'h0a; cycle(); slot_one = 1'b0;
        repeat (4) cycle();
        key_in = 8'hb0; repeat (4) cycle();
        rw = 1'b0; key_in = '0; cycle(); cycle();
        slot_one = 1'b1; log_start(); cycle(); slot_one = 1'b0; repeat (20) cycle(); logging = 1'b0;
        err = 0;
        if (obs_tone[4] != 8'h0a) err++;
        if (obs_tone[8] != 8'hb0) err++;
        if (LOOP) begin
            if (obs_tone[12] != 8'h0a) err++;
            if (obs_tone[16] != 8'hb0) err++;
            if (obs_tone[20] != 8'h0a) err++;
        end else begin
            if (obs_tone[12] != 8'h00 || !obs_done[12]) err++;
        end
        pin("play2_seq_errors", err, 0);
        if (LOOP) begin
            slot_one = 1'b1; cycle();
            pin("loop_stop_done", done, 1);
            pin("loop_stop_tone", tone_key, 0);
            slot_one = 1'b0; cycle();
        end

        // Random stimulus against the model.
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) rw = ~rw;
            slot_one = ($urandom_range(0, 11) == 0);
            slot_two = ($urandom_range(0, 11) == 0);
            key_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
